// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage RV32I pipeline: tracks destination
// tags in flight, registers EX operand-mux selects and generates stall/bubble/flush.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_is_link,
    input  logic              branch_taken,
    input  logic              ext_stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;

    // A tag's rd is folded to x0 whenever the slot is empty or does not write a
    // register, so "rd != 0" alone means "live producer". The WB stage needs no
    // tag at all: the register file is write-before-read, so WB is never bypassed.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              mem_read;
        logic              is_link;
    } ex_tag_t;

    ex_tag_t           ex_q, ex_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic [1:0]        sel_a_q, sel_a_d;
    logic [1:0]        sel_b_q, sel_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              load_use_c;
    logic              branch_c;
    logic              stall_c;
    logic              bubble_c;
    logic              count_c;

    function automatic logic src_hit(input logic [REG_AW-1:0] tag_rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              used);
        return used && (rs != '0) && (tag_rd == rs);
    endfunction

    function automatic logic [1:0] sel_for(input ex_tag_t           ex_tag,
                                           input logic [REG_AW-1:0] mem_rd,
                                           input logic [REG_AW-1:0] rs,
                                           input logic              used);
        logic [1:0] sel;
        sel = SEL_RF;
        if (src_hit(ex_tag.rd, rs, used)) begin
            sel = ex_tag.is_link ? SEL_LINK : SEL_ALU;
        end else if (src_hit(mem_rd, rs, used)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Hazard detection: ext_stall dominates, a taken branch kills the ID instruction.
    always_comb begin
        load_use_c = ex_q.mem_read && id_valid &&
                     (src_hit(ex_q.rd, id_rs1, id_rs1_used) ||
                      src_hit(ex_q.rd, id_rs2, id_rs2_used));
        branch_c   = branch_taken && !ext_stall;
        count_c    = load_use_c && !branch_c && !ext_stall;
        stall_c    = ext_stall || count_c;
        bubble_c   = !ext_stall && (branch_c || load_use_c);
    end

    // Next state: tags advance and selects are captured on the ID-to-EX edge.
    always_comb begin
        ex_d     = ex_q;
        mem_rd_d = mem_rd_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        cnt_d    = cnt_q;
        if (!ext_stall) begin
            mem_rd_d = ex_q.rd;
            if (bubble_c || !id_valid) begin
                ex_d    = '0;
                sel_a_d = SEL_RF;
                sel_b_d = SEL_RF;
            end else begin
                ex_d.rd       = id_reg_write ? id_rd : '0;
                ex_d.mem_read = id_mem_read;
                ex_d.is_link  = id_is_link;
                sel_a_d       = sel_for(ex_q, mem_rd_q, id_rs1, id_rs1_used);
                sel_b_d       = sel_for(ex_q, mem_rd_q, id_rs2, id_rs2_used);
            end
            if (count_c && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_rd_q <= '0;
            sel_a_q  <= SEL_RF;
            sel_b_q  <= SEL_RF;
            cnt_q    <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_rd_q <= mem_rd_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            cnt_q    <= cnt_d;
        end
    end

    // Hazard controls are forced low while reset is held so a stall drops at once.
    always_comb begin
        stall_if_id  = rst_n && stall_c;
        bubble_id_ex = rst_n && bubble_c;
        flush_if_id  = rst_n && branch_c;
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a queue-of-instructions pipeline model predicts
// every cycle's outputs, a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    typedef struct {
        bit       valid;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] rd;
        bit       rw, mr, lk;
    } instr_t;

    typedef struct {
        bit       stall, bub, flush;
        bit [1:0] sa, sb;
        int       cnt;
    } exp_t;

    localparam int K_ALU = 0, K_LD = 1, K_JL = 2, K_ST = 3, K_NOP = 4;

    logic             clk, rst_n;
    logic             id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_reg_write, id_mem_read, id_is_link;
    logic             branch_taken, ext_stall;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall_if_id, bubble_id_ex, flush_if_id;
    logic [CNT_W-1:0] stall_cnt;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_link(id_is_link), .branch_taken(branch_taken), .ext_stall(ext_stall),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   exp_q[$];

    // Reference model: pipe[0] is the instruction in EX, pipe[1] the one in MEM.
    instr_t pipe[$];
    bit [1:0] m_sa, m_sb;
    int     m_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_if_id",  int'(stall_if_id),  int'(e.stall));
            chk("bubble_id_ex", int'(bubble_id_ex), int'(e.bub));
            chk("flush_if_id",  int'(flush_if_id),  int'(e.flush));
            chk("fwd_a_sel",    int'(fwd_a_sel),    int'(e.sa));
            chk("fwd_b_sel",    int'(fwd_b_sel),    int'(e.sb));
            chk("stall_cnt",    int'(stall_cnt),    e.cnt);
        end
    end

    function automatic instr_t mk(input int kind, input int rd, input int rs1, input int rs2);
        instr_t i;
        i.valid = (kind != K_NOP);
        i.rd  = 5'(rd);
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        i.u1  = i.valid;
        i.u2  = i.valid && (kind == K_ALU || kind == K_ST);
        i.rw  = (kind == K_ALU || kind == K_LD || kind == K_JL);
        i.mr  = (kind == K_LD);
        i.lk  = (kind == K_JL);
        return i;
    endfunction

    function automatic bit produces(input instr_t p, input bit [4:0] rs, input bit used);
        return p.valid && p.rw && p.rd != 0 && p.rd == rs && used;
    endfunction

    // Nearest older producer wins: distance 1 comes from EX/MEM, distance 2 from MEM/WB.
    function automatic bit [1:0] sel_of(input bit [4:0] rs, input bit used);
        for (int d = 0; d < 2; d++) begin
            if (produces(pipe[d], rs, used)) begin
                if (d == 0) return pipe[0].lk ? 2'd3 : 2'd2;
                return 2'd1;
            end
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        instr_t none;
        none = mk(K_NOP, 0, 0, 0);
        pipe = {none, none};
        m_sa = 0; m_sb = 0; m_cnt = 0;
    endtask

    task automatic drive(input instr_t i, input bit br, input bit ext);
        id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_rs1_used = i.u1; id_rs2_used = i.u2; id_rd = i.rd;
        id_reg_write = i.rw; id_mem_read = i.mr; id_is_link = i.lk;
        branch_taken = br; ext_stall = ext;
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.stall = 0; e.bub = 0; e.flush = 0; e.sa = 0; e.sb = 0; e.cnt = 0;
        return e;
    endfunction

    // One clock cycle: drive, predict, let the edge happen, advance the model.
    task automatic step(input instr_t i, input bit br, input bit ext, output bit stalled);
        exp_t e;
        bit hz, br_eff;
        drive(i, br, ext);
        hz = i.valid && pipe[0].mr &&
             (produces(pipe[0], i.rs1, i.u1) || produces(pipe[0], i.rs2, i.u2));
        br_eff  = br && !ext;
        e.stall = ext || (hz && !br_eff);
        e.bub   = !ext && (br_eff || hz);
        e.flush = br_eff;
        e.sa = m_sa; e.sb = m_sb; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (!ext) begin
            if (hz && !br_eff && m_cnt < CMAX) m_cnt++;
            if (e.bub || !i.valid) begin
                m_sa = 0; m_sb = 0;
                pipe.push_front(mk(K_NOP, 0, 0, 0));
            end else begin
                m_sa = sel_of(i.rs1, i.u1);
                m_sb = sel_of(i.rs2, i.u2);
                pipe.push_front(i);
            end
            pipe = pipe[0:1];
        end
        stalled = e.stall;
    endtask

    // Present an instruction until it leaves ID.
    task automatic issue(input instr_t i);
        bit st;
        for (int n = 0; n < 8; n++) begin
            step(i, 0, 0, st);
            if (!st) return;
        end
        chk("issue_timeout", 1, 0);
    endtask

    task automatic do_random(input int cycles);
        instr_t cur;
        bit st, ext, br;
        int ext_left;
        ext_left = 0;
        cur = mk(K_ALU, 1, 2, 3);
        for (int c = 0; c < cycles; c++) begin
            if (ext_left == 0 && $urandom_range(9) == 0) ext_left = $urandom_range(3, 1);
            ext = (ext_left > 0);
            if (ext_left > 0) ext_left--;
            br = ($urandom_range(9) == 0);
            step(cur, br, ext, st);
            if (br && !ext) cur = mk(K_NOP, 0, 0, 0);
            else if (!st) begin
                int k;
                k = $urandom_range(9);
                k = (k < 4) ? K_ALU : (k < 6) ? K_LD : (k < 7) ? K_JL : (k < 8) ? K_ST : K_NOP;
                cur = mk(k, $urandom_range(7), $urandom_range(7), $urandom_range(7));
                cur.u1 = cur.u1 && ($urandom_range(7) != 0);
            end
        end
    endtask

    initial begin
        bit st;
        instr_t dep;
        rst_n = 1'b0;
        drive(mk(K_NOP, 0, 0, 0), 0, 0);
        model_reset();
        @(posedge clk); #1;
        exp_q.push_back(zero_exp());
        @(posedge clk); #1;
        exp_q.push_back(zero_exp());
        @(posedge clk); #1;
        rst_n = 1'b1;

        // load-use: one stall cycle, then both operands from MEM/WB, counter 0 -> 1
        issue(mk(K_LD, 5, 1, 0));
        issue(mk(K_ALU, 6, 5, 5));
        issue(mk(K_NOP, 0, 0, 0));
        // back-to-back ALU, distance-2, double producer, link
        issue(mk(K_ALU, 5, 1, 2));
        issue(mk(K_ALU, 6, 5, 3));
        issue(mk(K_NOP, 0, 0, 0));
        issue(mk(K_ALU, 7, 3, 5));
        issue(mk(K_ALU, 5, 1, 2));
        issue(mk(K_ALU, 5, 3, 4));
        issue(mk(K_ALU, 8, 5, 5));
        issue(mk(K_JL, 1, 0, 0));
        issue(mk(K_ALU, 2, 1, 0));
        // x0 never forwards or stalls
        issue(mk(K_ALU, 0, 1, 2));
        issue(mk(K_LD, 0, 1, 0));
        issue(mk(K_ALU, 3, 0, 0));
        // branch over a load-use hazard
        issue(mk(K_LD, 5, 1, 0));
        step(mk(K_ALU, 6, 5, 5), 1, 0, st);
        // ext_stall for 3 cycles with a pending branch, then released
        issue(mk(K_ALU, 7, 1, 2));
        repeat (3) step(mk(K_ALU, 8, 7, 7), 1, 1, st);
        step(mk(K_ALU, 8, 7, 7), 1, 0, st);
        // saturation: 17 load-use stalls
        repeat (17) begin
            issue(mk(K_LD, 5, 1, 0));
            issue(mk(K_ALU, 6, 5, 5));
        end
        // reset in the middle of a load-use stall
        issue(mk(K_LD, 5, 1, 0));
        dep = mk(K_ALU, 6, 5, 5);
        drive(dep, 0, 0);
        exp_q.push_back(zero_exp());
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        exp_q.push_back(zero_exp());
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_random(800);

        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage RV32I pipeline.
- Tracks destination-register tags through the EX, MEM and WB stages.
- Drives the 2-bit selects of the two EX-stage 4:1 operand muxes (A and B).
- Detects load-use hazards and branch flushes, generates stall/bubble/flush controls, and counts load-use stall cycles.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- id_is_link  in  1  ID instruction is JAL/JALR, so rd = PC+4.
- branch_taken  in  1  EX resolved a taken branch or jump.
- ext_stall  in  1  memory busy; freeze the whole pipeline.
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects, registered, valid during EX.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - EX, MEM and WB tags become invalid.
  - fwd_a_sel and fwd_b_sel = 2'b00.
  - stall_cnt = 0.
  - Combinational outputs evaluate to 0 while tags are invalid.
  - Reset mid-stall drops the stall immediately.
- Tag contents: valid, rd, reg_write, mem_read, is_link.
- Tag advance, each edge unless ext_stall:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, or an invalid tag when bubble_id_ex is high or id_valid is 0.
- Producer match for source rs against tag T: T.valid && T.reg_write && T.rd != 0 && T.rd == rs && rs_used. Register x0 never forwards and never stalls.
- Select encoding (fixed):
  - 00 = ID/EX register-file operand.
  - 01 = MEM/WB writeback data.
  - 10 = EX/MEM ALU result.
  - 11 = EX/MEM link value (PC+4).
- Select computation:
  - Registered on the same edge the ID instruction enters EX.
  - Computed from the current EX tag (the next MEM stage) and the current MEM tag (the next WB stage).
  - Priority: EX-tag match gives 11 if is_link, else 10. Otherwise a MEM-tag match gives 01. Otherwise 00.
  - No WB-tag bypass: the register file is write-before-read.
  - On a bubble edge, selects become 00.
- Load-use hazard, combinational: the EX tag has mem_read, id_valid is 1, and rs1 or rs2 matches the EX tag.
  - Result: stall_if_id = 1 and bubble_id_ex = 1 for exactly one cycle.
  - On the following edge the dependent instruction enters EX with select 01.
- Branch (branch_taken = 1 and ext_stall = 0):
  - flush_if_id = 1 and bubble_id_ex = 1.
  - The load-use stall is suppressed, because the ID instruction is killed.
- ext_stall = 1, highest priority:
  - stall_if_id = 1; bubble_id_ex = 0; flush_if_id = 0.
  - Tags, selects and stall_cnt all hold.
  - branch_taken is ignored and is acted on in the first cycle after ext_stall drops, since EX is frozen.
- stall_cnt: increments by 1 on every edge with a load-use stall that is not suppressed. It saturates at all-ones.
- Latency: selects are valid in the cycle after the ID-to-EX edge. Hazard outputs have zero latency (combinational from ID inputs and tags).

Test Plan:
- Back-to-back ALU dependence: `add x5,x1,x2` then `sub x6,x5,x3` -> sub in EX with fwd_a_sel = 10 and fwd_b_sel = 00; no stall.
- Distance-2 dependence: `add x5`, `nop`, `or x7,x3,x5` -> or in EX with fwd_b_sel = 01.
- Double hazard: `add x5`, `add x5`, `and x8,x5,x5` -> fwd_a_sel = fwd_b_sel = 10, with the newer producer winning.
- Link forwarding: `jal x1` then `addi x2,x1,4` -> fwd_a_sel = 11.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x5`:
  - Exactly one cycle with stall_if_id = 1 and bubble_id_ex = 1.
  - Then add in EX with both selects = 01.
  - stall_cnt goes 0 -> 1.
- x0 destination: writes to x0 never forward or stall; selects stay 00.
- Branch over load-use: branch_taken and a load-use hazard in the same cycle -> flush_if_id = 1, bubble_id_ex = 1, stall_if_id = 0, stall_cnt unchanged.
- ext_stall:
  - Held for 3 cycles mid-sequence -> selects and stall_cnt frozen, stall_if_id = 1.
  - A pending branch_taken flushes on the first cycle after release.
- Counter saturation: with CNT_W = 4, 17 load-use stalls -> stall_cnt = 15.
- Reset mid-stall: rst_n asserted during a load-use stall -> all outputs 0 immediately.
